seq_scan_ctrl: RTL and testbench
================================

// Module: seq_scan_ctrl
// PURPOSE
//  Controller that shares one overlapping serial pattern detector across a word stream.
//  Accepts WORD_W-bit words on a valid/ready input and serialises each word MSB-first
//  into the detector, one bit per clock.
//  Reports the per-word hit count on a valid/ready output and keeps a running total.
//  Sits between a parallel producer and status logic.
//  Detector history carries across word boundaries, so patterns spanning two words are found.
// PARAMETERS
//  WORD_W   8          input word width, >= 1
//  PAT_W    5          pattern length, 2..16
//  PATTERN  5'b10110   bit pattern to detect, MSB = first bit in time
//  CNT_W    8          width of the running-total counter
// PORTS
//  clk         in   1                          rising-edge clock
//  reset       in   1                          synchronous, active-high
//  in_valid    in   1                          producer has a word
//  in_data     in   WORD_W                     word; bit WORD_W-1 is serialised first
//  in_ready    out  1                          block can accept a word
//  clear_hist  in   1                          flush detector history (acted on in IDLE only)
//  out_valid   out  1                          per-word result available
//  out_hits    out  $clog2(WORD_W+1)           hits that ended inside this word
//  out_ready   in   1                          consumer takes the result
//  total_hits  out  CNT_W                      saturating sum of all hits since reset
//  busy        out  1                          high in SHIFT or REPORT
// BEHAVIOUR
//  - Reset values: state=IDLE, in_ready=1, out_valid=0, out_hits=0, total_hits=0,
//    busy=0, detector history and fill count cleared.
//  - A reset mid-operation drops the word in flight; no out_valid is produced for it.
//  - FSM states and transitions:
//    - IDLE: in_ready=1. If in_valid, latch in_data, set bit_idx=WORD_W-1 and go to SHIFT.
//    - SHIFT: in_ready=0. Each cycle, feed word[bit_idx] to the detector and decrement bit_idx.
//      After WORD_W cycles, go to REPORT.
//    - REPORT: out_valid=1, with out_hits held stable. If out_ready, go to IDLE
//      (in_ready rises the next cycle).
//  - Latency: accept at cycle 0, bits fed in cycles 1..WORD_W, out_valid asserted from cycle WORD_W+1.
//    Throughput is one word per WORD_W+2 cycles when out_ready is held high.
//  - Detector (Mealy, overlapping):
//    - hit = fill>=PAT_W-1 && {hist,bit}==PATTERN.
//    - hist <= {hist[PAT_W-3:0],bit}.
//    - fill saturates at PAT_W-1. The fill check prevents false hits after a flush.
//  - Hit accounting:
//    - Each hit increments the word hit counter (cleared on accept).
//    - Each hit also increments total_hits in the same cycle.
//    - total_hits saturates at 2^CNT_W-1 and never wraps.
//  - clear_hist: when sampled high in IDLE, flushes hist and fill. It is ignored in SHIFT and REPORT.
//    If clear_hist and in_valid are high in the same IDLE cycle, the flush applies first,
//    so the new word starts with empty history.
//  - Backpressure: while out_ready=0 in REPORT, out_valid and out_hits stay stable and in_ready=0.
// STRUCTURE
//  - Shared package seq_scan_pkg holds:
//    - state enum {IDLE, SHIFT, REPORT}
//    - default PATTERN and PAT_W constants
//    - a hits-width function clog2(WORD_W+1)
//  - One sub-module, pattern_match_core, contains hist, fill and the hit compare.
//    Its ports: clk, reset, flush, bit_valid, bit_in, hit.
//    The controller owns the FSM, the word register, bit_idx and the counters.
// TESTING
//  1. Reset, then word 8'b1011_0110 -> out_valid on cycle 9 with out_hits=2
//     (hits on bits 4 and 7, overlapping); total_hits=2.
//  2. From reset, word 8'b0000_1011, then word 8'b0000_0000 with no clear ->
//     out_hits=0, then 1 (cross-word hit); total_hits=1.
//  3. Same as test 2, with clear_hist pulsed in IDLE between the two words -> out_hits=0 and 0.
//  4. Hold out_ready=0 for 5 cycles in REPORT -> out_valid and out_hits stable, in_ready=0;
//     release -> in_ready=1 the next cycle.
//  5. CNT_W=4; eight words of 8'b1011_0110 -> total_hits reaches 15 and holds at 15;
//     out_hits=2 for every word.
//  6. Assert reset at bit 3 of SHIFT -> next cycle state=IDLE, outputs at reset values;
//     a following word 8'b1011_0110 still yields out_hits=2.

Source files
------------

// File: rtl/seq_scan_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module : seq_scan_pkg                                                      |
// | Brief  : Shared types and constants for the serial pattern scan controller |
// |          (FSM state encoding, default pattern, hit-count width helper).    |
// | Rev    : 1.0  initial release                                              |
// +----------------------------------------------------------------------------+
package seq_scan_pkg;

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_SHIFT  = 2'd1,
      S_REPORT = 2'd2
   } state_t;

   localparam int         DEF_PAT_W   = 5;
   localparam logic [4:0] DEF_PATTERN = 5'b10110;

   // Width needed to hold 0..word_w hits for a single word.
   function automatic int hits_w(input int word_w);
      return $clog2(word_w + 1);
   endfunction

endpackage : seq_scan_pkg
`default_nettype wire

// File: rtl/seq_scan_ctrl_match.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module : pattern_match_core                                                |
// | Brief  : Overlapping Mealy detector for a PAT_W-bit serial pattern. Keeps  |
// |          the last PAT_W-1 bits plus a fill count so no hit is reported     |
// |          until the history window holds real bits.                         |
// | Rev    : 1.0  initial release                                              |
// | Ports  : clk       in  clock                                               |
// |          reset     in  synchronous active-high reset                       |
// |          flush     in  clear history and fill count                        |
// |          bit_valid in  bit_in is a live bit this cycle                     |
// |          bit_in    in  serial data bit                                     |
// |          hit       out pattern completes on this bit (combinational)       |
// +----------------------------------------------------------------------------+
module pattern_match_core
   import seq_scan_pkg::*;
#(
   parameter int             PAT_W   = DEF_PAT_W,
   parameter logic [PAT_W-1:0] PATTERN = PAT_W'(DEF_PATTERN)
) (
   input  logic clk,
   input  logic reset,
   input  logic flush,
   input  logic bit_valid,
   input  logic bit_in,
   output logic hit
);

   localparam int                FILL_W   = $clog2(PAT_W);
   localparam logic [FILL_W-1:0] FILL_MAX = FILL_W'(PAT_W - 1);

   logic [PAT_W-2:0]  r_hist;
   logic [FILL_W-1:0] r_fill;
   logic [PAT_W-1:0]  w_window;

   // Window = stored history followed by the incoming bit (newest in LSB).
   assign w_window = {r_hist, bit_in};
   assign hit      = bit_valid && (r_fill == FILL_MAX) && (w_window == PATTERN);

   always_ff @(posedge clk) begin
      if (reset || flush) begin
         r_hist <= '0;
         r_fill <= '0;
      end else if (bit_valid) begin
         // Slicing the window keeps this valid for PAT_W == 2 as well.
         r_hist <= w_window[PAT_W-2:0];
         if (r_fill != FILL_MAX)
            r_fill <= r_fill + FILL_W'(1);
      end
   end

endmodule : pattern_match_core
`default_nettype wire

// File: rtl/seq_scan_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module : seq_scan_ctrl                                                     |
// | Brief  : Accepts words on a valid/ready input, serialises them MSB-first   |
// |          into a shared pattern detector and reports per-word hit counts    |
// |          on a valid/ready output, with a saturating running total.         |
// | Rev    : 1.0  initial release                                              |
// | Ports  : clk, reset            clock, synchronous active-high reset        |
// |          in_valid/in_ready     input word handshake, in_data = word        |
// |          clear_hist            flush detector history (IDLE only)          |
// |          out_valid/out_ready   result handshake, out_hits = hits in word   |
// |          total_hits            saturating hit total since reset            |
// |          busy                  high while shifting or reporting            |
// +----------------------------------------------------------------------------+
module seq_scan_ctrl
   import seq_scan_pkg::*;
#(
   parameter int               WORD_W  = 8,
   parameter int               PAT_W   = DEF_PAT_W,
   parameter logic [PAT_W-1:0] PATTERN = PAT_W'(DEF_PATTERN),
   parameter int               CNT_W   = 8
) (
   input  logic                        clk,
   input  logic                        reset,
   input  logic                        in_valid,
   input  logic [WORD_W-1:0]           in_data,
   output logic                        in_ready,
   input  logic                        clear_hist,
   output logic                        out_valid,
   output logic [hits_w(WORD_W)-1:0]   out_hits,
   input  logic                        out_ready,
   output logic [CNT_W-1:0]            total_hits,
   output logic                        busy
);

   localparam int HITS_W = hits_w(WORD_W);
   localparam int IDX_W  = (WORD_W > 1) ? $clog2(WORD_W) : 1;

   state_t              r_state;
   logic [WORD_W-1:0]   r_word;
   logic [IDX_W-1:0]    r_bit_idx;
   logic [HITS_W-1:0]   r_word_hits;
   logic [CNT_W-1:0]    r_total;
   logic                r_in_ready;
   logic                r_out_valid;
   logic                r_busy;

   logic                w_bit_valid;
   logic                w_bit;
   logic                w_flush;
   logic                w_hit;

   assign w_bit_valid = (r_state == S_SHIFT);
   assign w_bit       = r_word[r_bit_idx];
   // Flush lands on the same edge as an accept, so the new word sees empty history.
   assign w_flush     = (r_state == S_IDLE) && clear_hist;

   pattern_match_core #(
      .PAT_W   (PAT_W),
      .PATTERN (PATTERN)
   ) u_match (
      .clk       (clk),
      .reset     (reset),
      .flush     (w_flush),
      .bit_valid (w_bit_valid),
      .bit_in    (w_bit),
      .hit       (w_hit)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state     <= S_IDLE;
         r_word      <= '0;
         r_bit_idx   <= '0;
         r_word_hits <= '0;
         r_total     <= '0;
         r_in_ready  <= 1'b1;
         r_out_valid <= 1'b0;
         r_busy      <= 1'b0;
      end else begin
         // Hits only occur in SHIFT; the total saturates rather than wrapping.
         if (w_hit && (r_total != '1))
            r_total <= r_total + CNT_W'(1);

         case (r_state)
            S_IDLE: begin
               if (in_valid) begin
                  r_word      <= in_data;
                  r_bit_idx   <= IDX_W'(WORD_W - 1);
                  r_word_hits <= '0;
                  r_in_ready  <= 1'b0;
                  r_busy      <= 1'b1;
                  r_state     <= S_SHIFT;
               end
            end
            S_SHIFT: begin
               if (w_hit)
                  r_word_hits <= r_word_hits + HITS_W'(1);
               if (r_bit_idx == '0) begin
                  r_out_valid <= 1'b1;
                  r_state     <= S_REPORT;
               end else begin
                  r_bit_idx <= r_bit_idx - IDX_W'(1);
               end
            end
            S_REPORT: begin
               if (out_ready) begin
                  r_out_valid <= 1'b0;
                  r_in_ready  <= 1'b1;
                  r_busy      <= 1'b0;
                  r_state     <= S_IDLE;
               end
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   assign in_ready   = r_in_ready;
   assign out_valid  = r_out_valid;
   assign out_hits   = r_word_hits;
   assign total_hits = r_total;
   assign busy       = r_busy;

endmodule : seq_scan_ctrl
`default_nettype wire

// File: tb/tb_seq_scan_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module : tb_seq_scan_ctrl                                                  |
// | Brief  : Directed self-checking bench for seq_scan_ctrl. A second instance |
// |          with a 4-bit total counter shares the stimulus to exercise        |
// |          saturation.                                                       |
// | Rev    : 1.0  initial release                                              |
// +----------------------------------------------------------------------------+
module tb_seq_scan_ctrl;

   logic       clk = 1'b0;
   logic       reset;
   logic       in_valid;
   logic [7:0] in_data;
   logic       clear_hist;
   logic       out_ready;

   logic       in_ready,  in_ready2;
   logic       out_valid, out_valid2;
   logic [3:0] out_hits,  out_hits2;
   logic [7:0] total_hits;
   logic [3:0] total_hits2;
   logic       busy, busy2;

   int n_pass  = 0;
   int n_total = 0;

   int cap_cyc, cap_hits, cap_tot, cap_hits2, cap_tot2, cap_busy;
   int held_hits;

   always #5 clk = ~clk;

   seq_scan_ctrl #(.WORD_W(8), .CNT_W(8)) dut (
      .clk(clk), .reset(reset), .in_valid(in_valid), .in_data(in_data),
      .in_ready(in_ready), .clear_hist(clear_hist), .out_valid(out_valid),
      .out_hits(out_hits), .out_ready(out_ready), .total_hits(total_hits),
      .busy(busy)
   );

   seq_scan_ctrl #(.WORD_W(8), .CNT_W(4)) dut4 (
      .clk(clk), .reset(reset), .in_valid(in_valid), .in_data(in_data),
      .in_ready(in_ready2), .clear_hist(clear_hist), .out_valid(out_valid2),
      .out_hits(out_hits2), .out_ready(out_ready), .total_hits(total_hits2),
      .busy(busy2)
   );

   task automatic chk(input string tag, input int obs, input int exp);
      n_total++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
   endtask

   task automatic do_reset();
      @(negedge clk);
      reset = 1'b1;
      @(posedge clk);
      @(posedge clk);
      #1 reset = 1'b0;
   endtask

   // Present a word for one cycle; returns #1 after the accepting edge (cycle 1).
   task automatic start_word(input logic [7:0] w);
      @(negedge clk);
      in_data  = w;
      in_valid = 1'b1;
      @(posedge clk);
      #1 in_valid = 1'b0;
   endtask

   // Wait (bounded) for out_valid and capture the result of both instances.
   task automatic wait_result();
      int lat = 0;
      while (!out_valid && lat < 40) begin
         @(posedge clk);
         #1 lat++;
      end
      cap_cyc   = out_valid ? lat + 1 : 999;
      cap_hits  = int'(out_hits);
      cap_tot   = int'(total_hits);
      cap_hits2 = int'(out_hits2);
      cap_tot2  = int'(total_hits2);
      cap_busy  = int'(busy);
   endtask

   task automatic consume();
      @(posedge clk);
      #1;
   endtask

   initial begin
      reset      = 1'b1;
      in_valid   = 1'b0;
      in_data    = '0;
      clear_hist = 1'b0;
      out_ready  = 1'b1;

      // Reset state
      do_reset();
      chk("rst_in_ready",   int'(in_ready),   1);
      chk("rst_out_valid",  int'(out_valid),  0);
      chk("rst_out_hits",   int'(out_hits),   0);
      chk("rst_total",      int'(total_hits), 0);
      chk("rst_busy",       int'(busy),       0);
      chk("rst_in_ready4",  int'(in_ready2),  1);
      chk("rst_out_valid4", int'(out_valid2), 0);

      // 1: single word with two overlapping hits, result on cycle 9
      start_word(8'b1011_0110);
      chk("t1_busy_shift", int'(busy), 1);
      chk("t1_in_ready_shift", int'(in_ready), 0);
      wait_result();
      chk("t1_latency", cap_cyc,  9);
      chk("t1_hits",    cap_hits, 2);
      chk("t1_total",   cap_tot,  2);
      chk("t1_busy",    cap_busy, 1);
      consume();
      chk("t1_in_ready_after",  int'(in_ready),  1);
      chk("t1_out_valid_after", int'(out_valid), 0);

      // 2: cross-word hit with history carried over
      do_reset();
      start_word(8'b0000_1011);
      wait_result();
      chk("t2_w0_hits", cap_hits, 0);
      consume();
      start_word(8'b0000_0000);
      wait_result();
      chk("t2_w1_hits", cap_hits, 1);
      chk("t2_total",   cap_tot,  1);
      consume();

      // 3: same stream, history flushed in IDLE between words
      do_reset();
      start_word(8'b0000_1011);
      wait_result();
      chk("t3_w0_hits", cap_hits, 0);
      consume();
      @(negedge clk);
      clear_hist = 1'b1;
      @(negedge clk);
      clear_hist = 1'b0;
      start_word(8'b0000_0000);
      wait_result();
      chk("t3_w1_hits", cap_hits, 0);
      chk("t3_total",   cap_tot,  0);
      consume();

      // 4: backpressure holds the result stable
      do_reset();
      out_ready = 1'b0;
      start_word(8'b1011_0110);
      wait_result();
      chk("t4_latency", cap_cyc, 9);
      held_hits = cap_hits;
      chk("t4_hits", held_hits, 2);
      for (int i = 0; i < 5; i++) begin
         @(posedge clk);
         #1;
         chk("t4_hold_valid",    int'(out_valid), 1);
         chk("t4_hold_hits",     int'(out_hits),  2);
         chk("t4_hold_in_ready", int'(in_ready),  0);
      end
      @(negedge clk);
      out_ready = 1'b1;
      @(posedge clk);
      #1;
      chk("t4_release_in_ready",  int'(in_ready),  1);
      chk("t4_release_out_valid", int'(out_valid), 0);

      // 5: saturation of the 4-bit total; the 8-bit total keeps counting
      do_reset();
      for (int w = 1; w <= 9; w++) begin
         start_word(8'b1011_0110);
         wait_result();
         chk("t5_hits4", cap_hits2, 2);
         if (w == 7) chk("t5_total4_w7", cap_tot2, 14);
         if (w == 8) chk("t5_total4_w8", cap_tot2, 15);
         if (w == 9) chk("t5_total4_w9", cap_tot2, 15);
         if (w == 9) chk("t5_total8_w9", cap_tot,  18);
         consume();
      end

      // 6: reset during SHIFT drops the word
      do_reset();
      start_word(8'b1011_0110);
      @(posedge clk);
      #1;
      @(posedge clk);
      #1 reset = 1'b1;
      @(posedge clk);
      #1 reset = 1'b0;
      chk("t6_in_ready",  int'(in_ready),   1);
      chk("t6_out_valid", int'(out_valid),  0);
      chk("t6_out_hits",  int'(out_hits),   0);
      chk("t6_total",     int'(total_hits), 0);
      chk("t6_busy",      int'(busy),       0);
      for (int i = 0; i < 10; i++) begin
         @(posedge clk);
         #1 chk("t6_no_stale_valid", int'(out_valid), 0);
      end
      start_word(8'b1011_0110);
      wait_result();
      chk("t6_hits",  cap_hits, 2);
      chk("t6_total2", cap_tot, 2);
      consume();

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule : tb_seq_scan_ctrl
`default_nettype wire
